cpu_debug_action_scheduler: RTL and testbench

//  Serialises the one-cycle take_action_* strobes and jdo payload of the CPU debug slave into one

---
 rtl/cpu_debug_action_scheduler_if.sv | 20 ++
 rtl/cpu_debug_action_scheduler.sv | 174 +++++++++++++++++
 tb/tb_cpu_debug_action_scheduler.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_debug_action_scheduler_if.sv
// Command/response bus between the debug action scheduler (master) and the OCI executor (slave).
interface cpu_debug_action_scheduler_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_src;
    logic [37:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_error;
    logic [31:0] rsp_data;

    modport master (
        output cmd_valid, cmd_src, cmd_data,
        input  cmd_ready, rsp_valid, rsp_error, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_src, cmd_data,
        output cmd_ready, rsp_valid, rsp_error, rsp_data
    );
endinterface

// File: rtl/cpu_debug_action_scheduler.sv
// Serialises debug-slave take_action strobes into a FIFO-buffered command stream for the OCI
// executor, one outstanding command at a time, and reports completion through the monitor regs.
module cpu_debug_action_scheduler #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_action_break_a,
    input  logic        take_action_break_b,
    input  logic        take_action_break_c,
    input  logic        take_action_tracectrl,
    input  logic [37:0] jdo,
    cpu_debug_action_scheduler_if.master cmd_if,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    output logic        busy,
    output logic        overflow
);
    localparam int unsigned   AW         = $clog2(DEPTH);
    localparam int unsigned   CW         = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [7:0]    TMO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RSP
    } state_e;

    logic [5:0]    req;
    logic [2:0]    req_src;
    logic          req_any;
    logic          req_multi;
    logic          push;
    logic          pop;
    logic          fifo_full;

    logic [40:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    state_e        state_q;
    logic          cmd_valid_q;
    logic [2:0]    cmd_src_q;
    logic [37:0]   cmd_data_q;
    logic [31:0]   mondreg_q;
    logic          mon_ready_q;
    logic          mon_error_q;
    logic [7:0]    tmo_q;

    // Bit index equals the cmd_src code, so the lowest set bit is the highest priority.
    assign req = {take_action_tracectrl, take_action_break_c, take_action_break_b,
                  take_action_break_a, take_action_ocimem_b, take_action_ocimem_a};

    always_comb begin
        req_src = 3'd0;
        for (int unsigned i = 6; i > 0; i--) begin
            if (req[i-1]) begin
                req_src = 3'(i - 1);
            end
        end
        req_any   = |req;
        req_multi = (req & (req - 6'd1)) != 6'd0;
    end

    assign fifo_full = (count_q == FULL_COUNT);
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign push      = req_any && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | req_multi | (req_any & ~push);
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_src, jdo};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_src_q   <= '0;
            cmd_data_q  <= '0;
            mondreg_q   <= '0;
            mon_ready_q <= 1'b1;
            mon_error_q <= 1'b0;
            tmo_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        {cmd_src_q, cmd_data_q} <= mem_q[rd_ptr_q];
                        cmd_valid_q             <= 1'b1;
                        mon_ready_q             <= 1'b0;
                        mon_error_q             <= 1'b0;
                        state_q                 <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_if.cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        tmo_q       <= '0;
                        state_q     <= S_WAIT_RSP;
                    end
                end
                S_WAIT_RSP: begin
                    // tmo_q counts completed WAIT_RSP cycles; abort on the TIMEOUT-th silent one.
                    if (cmd_if.rsp_valid) begin
                        mon_ready_q <= 1'b1;
                        mon_error_q <= cmd_if.rsp_error;
                        if (!cmd_if.rsp_error) begin
                            mondreg_q <= cmd_if.rsp_data;
                        end
                        state_q <= S_IDLE;
                    end else if (tmo_q == TMO_LAST) begin
                        mon_ready_q <= 1'b1;
                        mon_error_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_if.cmd_valid = cmd_valid_q;
    assign cmd_if.cmd_src   = cmd_src_q;
    assign cmd_if.cmd_data  = cmd_data_q;
    assign MonDReg          = mondreg_q;
    assign monitor_ready    = mon_ready_q;
    assign monitor_error    = mon_error_q;
    assign overflow         = overflow_q;
    assign busy             = (count_q != '0) || (state_q != S_IDLE);
endmodule

// File: tb/tb_cpu_debug_action_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
module tb_cpu_debug_action_scheduler;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        ta_ocimem_a, ta_ocimem_b, ta_break_a, ta_break_b, ta_break_c, ta_tracectrl;
    logic [37:0] jdo;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error, busy, overflow;

    cpu_debug_action_scheduler_if bus ();

    cpu_debug_action_scheduler #(
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .take_action_ocimem_a (ta_ocimem_a),
        .take_action_ocimem_b (ta_ocimem_b),
        .take_action_break_a  (ta_break_a),
        .take_action_break_b  (ta_break_b),
        .take_action_break_c  (ta_break_c),
        .take_action_tracectrl(ta_tracectrl),
        .jdo                  (jdo),
        .cmd_if               (bus),
        .MonDReg              (MonDReg),
        .monitor_ready        (monitor_ready),
        .monitor_error        (monitor_error),
        .busy                 (busy),
        .overflow             (overflow)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: pending-request queue plus the phase of the one outstanding command.
    logic [40:0] mq[$];
    int          mph;     // 0 = no command, 1 = offered to executor, 2 = awaiting response
    int          mwait;   // WAIT_RSP cycles elapsed for the outstanding command
    int          n_accept;
    logic        m_valid, m_rdy, m_err, m_ovf;
    logic [2:0]  m_src;
    logic [37:0] m_data;
    logic [31:0] m_mon;

    task automatic model_step(input logic [5:0] s, input logic [37:0] j, input logic rdy,
                              input logic rv, input logic re, input logic [31:0] rd,
                              input logic rst);
        bit          pop;
        int          src;
        logic [40:0] e;
        if (rst) begin
            mq.delete();
            mph = 0; mwait = 0;
            m_valid = 0; m_src = 0; m_data = 0; m_mon = 0; m_rdy = 1; m_err = 0; m_ovf = 0;
            return;
        end
        pop = (mph == 0) && (mq.size() != 0);
        e   = '0;
        src = 0;
        for (int i = 5; i >= 0; i--) if (s[i]) src = i;
        if (pop) e = mq.pop_front();
        if ($countones(s) > 1) m_ovf = 1;
        if (s != 0) begin
            if (mq.size() < DEPTH) mq.push_back({3'(src), j});
            else m_ovf = 1;
        end
        case (mph)
            0: if (pop) begin
                {m_src, m_data} = e;
                m_valid = 1; m_rdy = 0; m_err = 0; mph = 1;
            end
            1: if (rdy) begin
                m_valid = 0; mwait = 0; mph = 2; n_accept++;
            end
            default: begin
                mwait++;
                if (rv) begin
                    m_rdy = 1; m_err = re;
                    if (!re) m_mon = rd;
                    mph = 0;
                end else if (mwait == TIMEOUT) begin
                    m_rdy = 1; m_err = 1; mph = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        chk("cmd_valid", bus.cmd_valid, m_valid);
        chk("cmd_src", bus.cmd_src, m_src);
        chk("cmd_data", bus.cmd_data, m_data);
        chk("MonDReg", MonDReg, m_mon);
        chk("monitor_ready", monitor_ready, m_rdy);
        chk("monitor_error", monitor_error, m_err);
        chk("busy", busy, (mq.size() != 0) || (mph != 0));
        chk("overflow", overflow, m_ovf);
    endtask

    function automatic logic [37:0] rnd_jdo();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[37:0];
    endfunction

    task automatic step(input logic [5:0] s, input logic [37:0] j, input logic rdy,
                        input logic rv, input logic re, input logic [31:0] rd, input logic rst);
        @(negedge clk);
        reset = rst;
        {ta_tracectrl, ta_break_c, ta_break_b, ta_break_a, ta_ocimem_b, ta_ocimem_a} = s;
        jdo = j;
        bus.cmd_ready = rdy;
        bus.rsp_valid = rv;
        bus.rsp_error = re;
        bus.rsp_data  = rd;
        @(posedge clk);
        model_step(s, j, rdy, rv, re, rd, rst);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        step(6'd0, rnd_jdo(), 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic idle(input logic rdy);
        step(6'd0, rnd_jdo(), rdy, 1'b0, 1'b0, $urandom(), 1'b0);
    endtask

    task automatic drain(output int acc);
        int start;
        start = n_accept;
        for (int k = 0; k < 400 && (mq.size() != 0 || mph != 0); k++)
            step(6'd0, rnd_jdo(), 1'b1, mph == 2, 1'b0, $urandom(), 1'b0);
        chk("drain_idle", busy, 0);
        acc = n_accept - start;
    endtask

    task automatic run_cmd(input logic [5:0] s, input logic re, input logic [31:0] rd);
        step(s, rnd_jdo(), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int k = 0; k < 20 && mph != 2; k++) idle(1'b1);
        chk("run_cmd_accept", busy && !bus.cmd_valid, 1);
        step(6'd0, rnd_jdo(), 1'b0, 1'b1, re, rd, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [5:0] s;
        reset = 1'b1;
        {ta_tracectrl, ta_break_c, ta_break_b, ta_break_a, ta_ocimem_a, ta_ocimem_b} = '0;
        jdo = '0;
        bus.cmd_ready = 0; bus.rsp_valid = 0; bus.rsp_error = 0; bus.rsp_data = '0;

        // 1: single ocimem_a command, two-cycle issue latency, good response
        do_reset();
        step(6'b000001, 38'h2_0000_1234, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("t1_valid_early", bus.cmd_valid, 0);
        idle(1'b1);
        chk("t1_valid", bus.cmd_valid, 1);
        chk("t1_src", bus.cmd_src, 0);
        chk("t1_data", bus.cmd_data, 38'h2_0000_1234);
        idle(1'b1);
        idle(1'b0);
        step(6'd0, rnd_jdo(), 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0);
        chk("t1_mondreg", MonDReg, 32'hCAFE_F00D);
        chk("t1_ready", monitor_ready, 1);
        chk("t1_error", monitor_error, 0);

        // 2: simultaneous break_a + tracectrl keeps only break_a
        step(6'b100100, rnd_jdo(), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("t2_overflow", overflow, 1);
        idle(1'b0);
        chk("t2_src", bus.cmd_src, 2);
        drain(n);
        chk("t2_ncmd", n, 1);

        // 3: executor stalled, six single strobes: one issued, four queued, sixth dropped
        do_reset();
        foreach (s[i]) begin end
        step(6'b000010, rnd_jdo(), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(6'b001000, rnd_jdo(), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(6'b010000, rnd_jdo(), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(6'b100000, rnd_jdo(), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(6'b000001, rnd_jdo(), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("t3_ovf_before", overflow, 0);
        step(6'b000100, rnd_jdo(), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("t3_ovf_after", overflow, 1);
        drain(n);
        chk("t3_ncmd", n, 5);

        // 4: response timeout on the second command, third then issues
        do_reset();
        step(6'b000010, rnd_jdo(), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(6'b001000, rnd_jdo(), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(6'b100000, rnd_jdo(), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int k = 0; k < 10 && mph != 2; k++) idle(1'b1);
        step(6'd0, rnd_jdo(), 1'b0, 1'b1, 1'b0, 32'h5A5A_0004, 1'b0);
        for (int k = 0; k < 10 && mph != 2; k++) idle(1'b1);
        n = 0;
        while (n < 300 && !monitor_ready) begin
            idle(1'b1);
            n++;
        end
        chk("t4_timeout_cycles", n, TIMEOUT);
        chk("t4_error", monitor_error, 1);
        chk("t4_mondreg_held", MonDReg, 32'h5A5A_0004);
        idle(1'b0);
        chk("t4_next_valid", bus.cmd_valid, 1);
        chk("t4_next_src", bus.cmd_src, 5);
        drain(n);

        // 5: error response leaves MonDReg untouched
        run_cmd(6'b000001, 1'b0, 32'h7777_0005);
        run_cmd(6'b000010, 1'b1, 32'h1111_1111);
        chk("t5_error", monitor_error, 1);
        chk("t5_ready", monitor_ready, 1);
        chk("t5_mondreg", MonDReg, 32'h7777_0005);

        // 6: reset while awaiting a response with two entries queued
        step(6'b000001, rnd_jdo(), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(6'b010000, rnd_jdo(), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        step(6'b000100, rnd_jdo(), 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int k = 0; k < 10 && mph != 2; k++) idle(1'b1);
        chk("t6_in_wait", busy && !bus.cmd_valid, 1);
        do_reset();
        chk("t6_valid", bus.cmd_valid, 0);
        chk("t6_src", bus.cmd_src, 0);
        chk("t6_data", bus.cmd_data, 0);
        chk("t6_mondreg", MonDReg, 0);
        chk("t6_ready", monitor_ready, 1);
        chk("t6_error", monitor_error, 0);
        chk("t6_busy", busy, 0);
        chk("t6_overflow", overflow, 0);
        for (int k = 0; k < 3; k++) step(6'd0, rnd_jdo(), 1'b1, 1'b1, 1'b0, $urandom(), 1'b0);
        chk("t6_rsp_ignored", MonDReg, 0);
        chk("t6_busy_after", busy, 0);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < 6; b++) s[b] = ($urandom_range(0, 11) == 0);
            step(s, rnd_jdo(), $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, $urandom(), $urandom_range(0, 499) == 0);
        end
        drain(n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
